conv_operand_store: RTL and testbench

- Parametrised, loadable operand store for the convolution datapath: holds one IMG_DIM x IMG_DIM input image and one K_DIM x K_DIM filter.
- Replaces hard-wired operand constants with a streamed valid/ready load port driven by a small load FSM.
- Exposes all stored operands in parallel (flattened buses), plus a registered K_DIM x K_DIM window extracted at a selectable (row, col).
- Sits between the operand source (testbench or host loader) and the MAC array.

---
 rtl/conv_pkg.sv | 9 +
 rtl/conv_window_sel.sv | 29 ++
 rtl/conv_operand_store.sv | 107 ++++++++++
 tb/tb_conv_operand_store.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and defaults for the convolution operand store.
package conv_pkg;
   typedef enum logic [1:0] {IDLE, LOAD_IMG, LOAD_FLT, DONE} state_t;
   localparam int DATA_W_DEF  = 8;
   localparam int IMG_DIM_DEF = 4;
   localparam int K_DIM_DEF   = 3;
   localparam logic LOAD_MODE_FULL = 1'b0;
   localparam logic LOAD_MODE_FLT  = 1'b1;
endpackage

// File: rtl/conv_window_sel.sv
// conv_window_sel: combinational K_DIM x K_DIM window tap from the flattened image,
// zeroed and flagged when the window would run past the image edge.
module conv_window_sel
   import conv_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IMG_DIM = IMG_DIM_DEF,
   parameter int K_DIM   = K_DIM_DEF,
   parameter int POS_W   = $clog2(IMG_DIM) + 1
) (
   input  logic [IMG_DIM*IMG_DIM*DATA_W-1:0] i_img_flat,
   input  logic [POS_W-1:0]                  i_win_row,
   input  logic [POS_W-1:0]                  i_win_col,
   output logic [K_DIM*K_DIM*DATA_W-1:0]     o_win_flat,
   output logic                              o_win_oob
);
   logic [POS_W-1:0] w_row;
   logic [POS_W-1:0] w_col;
   assign o_win_oob = (int'(i_win_row) > IMG_DIM - K_DIM) || (int'(i_win_col) > IMG_DIM - K_DIM);
   // clamp the origin when out of range so the part-selects never leave the image
   assign w_row = o_win_oob ? '0 : i_win_row;
   assign w_col = o_win_oob ? '0 : i_win_col;
   for (genvar r = 0; r < K_DIM; r++) begin : g_r
      for (genvar c = 0; c < K_DIM; c++) begin : g_c
         assign o_win_flat[(r*K_DIM+c)*DATA_W +: DATA_W] = o_win_oob ? '0 :
            i_img_flat[((int'(w_row)+r)*IMG_DIM + int'(w_col) + c)*DATA_W +: DATA_W];
      end
   end
endmodule

// File: rtl/conv_operand_store.sv
// conv_operand_store: streamed loader for one image and one filter, exposing all
// operands in parallel plus a registered window at a selectable position.
module conv_operand_store
   import conv_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IMG_DIM = IMG_DIM_DEF,
   parameter int K_DIM   = K_DIM_DEF,
   parameter int POS_W   = $clog2(IMG_DIM) + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_load_start,
   input  logic                              i_load_mode,
   input  logic                              i_in_valid,
   input  logic [DATA_W-1:0]                 i_in_data,
   output logic                              o_in_ready,
   output logic                              o_loaded,
   output logic                              o_busy,
   output logic [IMG_DIM*IMG_DIM*DATA_W-1:0] o_img_flat,
   output logic [K_DIM*K_DIM*DATA_W-1:0]     o_flt_flat,
   input  logic [POS_W-1:0]                  i_win_row,
   input  logic [POS_W-1:0]                  i_win_col,
   output logic [K_DIM*K_DIM*DATA_W-1:0]     o_win_flat,
   output logic                              o_win_oob
);
   localparam int NI    = IMG_DIM * IMG_DIM;
   localparam int NK    = K_DIM * K_DIM;
   localparam int CNT_W = NI > 1 ? $clog2(NI) : 1;
   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic [NI*DATA_W-1:0]     r_img;
   logic [NK*DATA_W-1:0]     r_flt;
   logic [NK*DATA_W-1:0]     r_win;
   logic                     r_oob;
   logic [NK*DATA_W-1:0]     w_win;
   logic                     w_oob;
   logic                     w_beat;
   logic                     w_img_last;
   logic                     w_flt_last;
   assign o_in_ready = (r_state == LOAD_IMG) || (r_state == LOAD_FLT);
   assign o_busy     = o_in_ready;
   assign o_loaded   = r_state == DONE;
   assign o_img_flat = r_img;
   assign o_flt_flat = r_flt;
   assign o_win_flat = r_win;
   assign o_win_oob  = r_oob;
   assign w_beat     = i_in_valid & o_in_ready;
   assign w_img_last = r_cnt == CNT_W'(NI - 1);
   assign w_flt_last = r_cnt == CNT_W'(NK - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // a restart overrides any phase change from a beat landing in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_beat) begin
         w_cnt_nxt = r_cnt + 1'b1;
         if (r_state == LOAD_IMG && w_img_last) begin
            w_state_nxt = LOAD_FLT;
            w_cnt_nxt   = '0;
         end
         if (r_state == LOAD_FLT && w_flt_last) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
         end
      end
      if (i_load_start) begin
         w_state_nxt = (i_load_mode == LOAD_MODE_FLT) ? LOAD_FLT : LOAD_IMG;
         w_cnt_nxt   = '0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_img <= '0;
         r_flt <= '0;
         r_win <= '0;
         r_oob <= 1'b0;
      end else begin
         if (w_beat && r_state == LOAD_IMG) r_img[r_cnt*DATA_W +: DATA_W] <= i_in_data;
         if (w_beat && r_state == LOAD_FLT) r_flt[r_cnt*DATA_W +: DATA_W] <= i_in_data;
         r_win <= w_win;
         r_oob <= w_oob;
      end
   end
   conv_window_sel #(
      .DATA_W  (DATA_W),
      .IMG_DIM (IMG_DIM),
      .K_DIM   (K_DIM),
      .POS_W   (POS_W)
   ) u_win (
      .i_img_flat (r_img),
      .i_win_row  (i_win_row),
      .i_win_col  (i_win_col),
      .o_win_flat (w_win),
      .o_win_oob  (w_oob)
   );
endmodule

// File: tb/tb_conv_operand_store.sv
// tb_conv_operand_store: directed and random load/window traffic checked against
// a linear-position operand model.
module tb_conv_operand_store;
   localparam int DW = 8, ID = 4, KD = 3, PW = $clog2(ID) + 1, NI = ID*ID, NK = KD*KD;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_load_start = 0, i_load_mode = 0, i_in_valid = 0;
   logic [DW-1:0] i_in_data = '0;
   logic [PW-1:0] i_win_row = '0, i_win_col = '0;
   logic o_in_ready, o_loaded, o_busy, o_win_oob;
   logic [NI*DW-1:0] o_img_flat;
   logic [NK*DW-1:0] o_flt_flat, o_win_flat;
   int n_cmp = 0, n_bad = 0;
   int img_s[NI] = '{15,225,61,68,169,40,71,140,120,9,253,246,12,151,232,234};
   int flt_s[NK] = '{175,196,212,117,241,69,9,255,188};
   logic [7:0] m_img[NI];
   logic [7:0] m_flt[NK];
   bit m_busy, m_loaded, m_full, m_oob;
   int m_pos, m_need;
   logic [NK*DW-1:0] m_win;
   always #5 clk = ~clk;
   conv_operand_store dut (
      .clk(clk), .rst(rst), .i_load_start(i_load_start), .i_load_mode(i_load_mode),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
      .o_loaded(o_loaded), .o_busy(o_busy), .o_img_flat(o_img_flat), .o_flt_flat(o_flt_flat),
      .i_win_row(i_win_row), .i_win_col(i_win_col), .o_win_flat(o_win_flat), .o_win_oob(o_win_oob)
   );
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [127:0] pack_img();
      logic [127:0] v = '0;
      for (int i = 0; i < NI; i++) v[i*DW +: DW] = m_img[i];
      return v;
   endfunction
   function automatic logic [127:0] pack_flt();
      logic [127:0] v = '0;
      for (int i = 0; i < NK; i++) v[i*DW +: DW] = m_flt[i];
      return v;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < NI; i++) m_img[i] = '0;
      for (int i = 0; i < NK; i++) m_flt[i] = '0;
      m_busy = 0; m_loaded = 0; m_full = 0; m_oob = 0; m_pos = 0; m_need = 0; m_win = '0;
   endtask
   task automatic check_all();
      check("ready", 128'(o_in_ready), 128'(m_busy));
      check("busy", 128'(o_busy), 128'(m_busy));
      check("loaded", 128'(o_loaded), 128'(m_loaded));
      check("img", o_img_flat, pack_img());
      check("flt", 128'(o_flt_flat), pack_flt());
      check("win", 128'(o_win_flat), 128'(m_win));
      check("oob", 128'(o_win_oob), 128'(m_oob));
   endtask
   task automatic cyc(input bit ls, input bit lm, input bit v, input logic [7:0] d, input int wr, input int wc);
      i_load_start = ls; i_load_mode = lm; i_in_valid = v; i_in_data = d;
      i_win_row = PW'(wr); i_win_col = PW'(wc);
      m_oob = (wr > ID - KD) || (wc > ID - KD);
      m_win = '0;
      if (!m_oob)
         for (int r = 0; r < KD; r++)
            for (int c = 0; c < KD; c++) m_win[(r*KD+c)*DW +: DW] = m_img[(wr+r)*ID + wc + c];
      if (m_busy && v) begin
         if (m_full && m_pos < NI) m_img[m_pos] = d;
         else m_flt[m_full ? m_pos - NI : m_pos] = d;
         m_pos++;
         if (m_pos == m_need) begin m_busy = 0; m_loaded = 1; end
      end
      if (ls) begin
         m_busy = 1; m_loaded = 0; m_full = !lm; m_need = lm ? NK : NI + NK; m_pos = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask
   initial begin
      logic [71:0] win11 = {8'd234,8'd232,8'd151,8'd246,8'd253,8'd9,8'd140,8'd71,8'd40};
      logic [127:0] ref_v;
      int xfers;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;
      repeat (3) cyc(0, 0, 1, 8'($urandom), 0, 0);
      check("idle_img", o_img_flat, '0);
      // full load with two idle gaps
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < NI + NK; i++) begin
         if (i == 5 || i == 18) cyc(0, 0, 0, 8'hAA, 0, 0);
         cyc(0, 0, 1, 8'(i < NI ? img_s[i] : flt_s[i-NI]), 0, 0);
      end
      check("loaded_after_25", 128'(o_loaded), 128'(1));
      cyc(0, 0, 0, 0, 1, 1);
      check("win11", 128'(o_win_flat), 128'(win11));
      check("win11_oob", 128'(o_win_oob), 128'(0));
      cyc(0, 0, 0, 0, 2, 0);
      check("win20_oob", 128'(o_win_oob), 128'(1));
      check("win20_zero", 128'(o_win_flat), 128'(0));
      // filter-only reload; image must be preserved
      cyc(1, 1, 0, 0, 0, 0);
      xfers = 0;
      for (int i = 0; i < NK + 2; i++) begin
         if (o_in_ready) xfers++;
         cyc(0, 0, 1, 8'(i + 1), 1, 1);
      end
      check("xfers", 128'(xfers), 128'(NK));
      ref_v = '0;
      for (int i = 0; i < NK; i++) ref_v[i*DW +: DW] = 8'(i + 1);
      check("flt_1to9", 128'(o_flt_flat), ref_v);
      ref_v = '0;
      for (int i = 0; i < NI; i++) ref_v[i*DW +: DW] = 8'(img_s[i]);
      check("img_kept", o_img_flat, ref_v);
      // restart on image beat 7
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'($urandom), 0, 0);
      cyc(1, 0, 1, 8'($urandom), 0, 0);
      for (int i = 0; i < NI + NK; i++) begin
         if (i == NI + NK - 1) check("not_loaded_early", 128'(o_loaded), 128'(0));
         cyc(0, 0, 1, 8'($urandom), 0, 0);
      end
      check("loaded_restart", 128'(o_loaded), 128'(1));
      // restart coincident with final filter beat
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < NI + NK - 1; i++) cyc(0, 0, 1, 8'($urandom), 0, 0);
      cyc(1, 1, 1, 8'h5C, 0, 0);
      check("busy_restart", 128'(o_busy), 128'(1));
      check("no_done", 128'(o_loaded), 128'(0));
      for (int i = 0; i < NK; i++) cyc(0, 0, 1, 8'($urandom), 1, 0);
      // asynchronous reset in the middle of the filter phase
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < NI + 3; i++) cyc(0, 0, 1, 8'($urandom), 1, 1);
      #2 rst = 1'b0;
      #1 model_reset();
      check_all();
      check("rst_img_now", o_img_flat, '0);
      @(negedge clk);
      rst = 1'b1;
      cyc(0, 0, 1, 8'h11, 0, 0);
      check("post_rst_ready", 128'(o_in_ready), 128'(0));
      repeat (400)
         cyc($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
             8'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
